div_ratio_checker: RTL and testbench
====================================

# div_ratio_checker

Downstream self-check stage for the clock divider. It samples the divided outputs `clk_div2`, `clk_div4` and `clk_div8` as data in the `clk` domain and measures each channel's period in `clk` cycles. Each channel locks after a run of correct periods and raises a sticky fault when a locked channel breaks ratio or stalls. The block feeds lock/fault status to the system status register and to bring-up benches.

## Interface
- `LOCK_COUNT`, default 4: consecutive correct periods required before a channel locks (range 1..15).
- `CNT_W`, default 5: width of each channel's period counter; must satisfy 2^CNT_W > 16.
- `clk`  input  1  system clock; also clocks the divider.
- `rst`  input  1  reset, synchronous, active-low.
- `en`  input  1  checking enable; low forces every channel to IDLE.
- `clr_fault`  input  1  one-cycle pulse that clears the sticky `fault` bits.
- `clk_div2`, `clk_div4`, `clk_div8`  input  1 each  divider outputs, driven by registers on `clk` rising edge.
- `locked`  output  3  per-channel lock; bit0 = div2, bit1 = div4, bit2 = div8.
- `fault`  output  3  per-channel sticky fault, same bit order.
- `all_locked`  output  1  registered AND of `locked`.

## Operation
- Channel i has expected period P = 2^(i+1), giving 2, 4 and 8.
- Each channel registers its input into `prev`. An edge pulse fires when the input is 1 and `prev` is 0.
- Period counter:
  - Loads 1 on an edge pulse and increments on every other cycle.
  - Saturates at 2^CNT_W−1.
  - The value held on the cycle an edge pulse fires is the measured period.
- Per-channel FSM:
  - **IDLE**: entered on reset or when `en`=0. Move to SYNC when `en`=1.
  - **SYNC**: wait for the first edge pulse. Counter starts; good count = 0. Move to CHECK.
  - **CHECK**: on each edge pulse, if the period equals P, increment the good count; otherwise reset the good count to 0. CHECK never raises a fault. When the good count reaches LOCK_COUNT, move to LOCKED.
  - **LOCKED**: `locked[i]`=1. A fault is either an edge pulse with period ≠ P, or the counter reaching 2P with no edge (stall). On a fault, set `fault[i]`, clear `locked[i]` and move to SYNC.
- `fault` bits stay set until `clr_fault` or reset. If `clr_fault` coincides with a new fault on the same channel, the set wins.
- `en` falling mid-operation: all channels go to IDLE, `locked` clears and the good counts clear. `fault` is retained.
- Channels are fully independent. A fault on one channel never disturbs another.

## Timing
- Reset (`rst`=0 at a `clk` rising edge): `locked`=0, `fault`=0, `all_locked`=0, every FSM in IDLE, counters and `prev` cleared. Values take effect on the output the cycle after that edge.
- All outputs are registered.
- `locked[i]` rises 1 cycle after the edge pulse that completes the LOCK_COUNT-th good period.
- `all_locked` follows `locked` by 1 further cycle.
- Fault latency:
  - Period-error fault: 1 cycle after the offending edge pulse.
  - Stall fault: 1 cycle after the counter reaches 2P.
- Edge-pulse latency: 1 cycle after the input transition is registered.
- With an ideal divider and LOCK_COUNT=4:
  - div2 locks 8 cycles after its first edge pulse, plus 1 cycle.
  - div4 locks 16 cycles after its first edge pulse, plus 1 cycle.
  - div8 locks 32 cycles after its first edge pulse, plus 1 cycle.

## Configuration
- `DUTY_CHECK_EN`
  - **Defined**: each channel also counts high cycles. The high count is captured on the falling edge of the registered input. A high time ≠ P/2 counts as a bad period: it resets the good count in CHECK and raises a fault in LOCKED. The fault latency is 1 cycle after the falling edge.
  - **Undefined**: only the period is checked. The duty logic is absent.

## Test plan
- **Lock from reset.** Release reset with `en`=1 and an ideal divider, LOCK_COUNT=4.
  - `locked` = 001, then 011, then 111 at the cycle counts given in Timing.
  - `all_locked`=1 one cycle after `locked`=111.
  - `fault` stays 000.
- **Stall on div4.** After lock, hold `clk_div4` at 0 for 12 cycles.
  - `fault[1]`=1 and `locked[1]`=0 one cycle after the counter reaches 8.
  - `all_locked` drops.
  - div4 relocks after 4 good periods once the input is restored; `fault[1]` stays 1.
- **Ratio error on div8.** After lock, inject one period of 6 on div8.
  - `fault[2]`=1 one cycle after the offending edge.
  - Bits 0 and 1 of `locked` and `fault` are unchanged.
- **Clear-versus-set collision.** Pulse `clr_fault` on the same cycle a new div2 fault is flagged.
  - `fault[0]` remains 1.
  - A `clr_fault` pulse on a quiet cycle clears `fault` to 000.
- **Enable and reset mid-operation.**
  - Drop `en` for 3 cycles while locked: `locked`=000 next cycle and `fault` is held. Relock again requires the full LOCK_COUNT.
  - Separately, assert `rst`=0 mid-CHECK: all outputs are 0 the next cycle.
- **Duty check.** Drive div4 with high time 1 and low time 3, so the period stays 4.
  - With `DUTY_CHECK_EN`: `locked[1]` never rises.
  - Without `DUTY_CHECK_EN`: div4 locks normally.

Source files
------------

// File: rtl/div_ratio_checker.sv
// Lock/fault checker for the div2/div4/div8 divider outputs, sampled as data on clk.
// Define DUTY_CHECK_EN to also require each high phase to last exactly half a period.
module div_ratio_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr_fault,
    input  logic       clk_div2,
    input  logic       clk_div4,
    input  logic       clk_div8,
    output logic [2:0] locked,
    output logic [2:0] fault,
    output logic       all_locked
);

    localparam int unsigned      NumCh   = 3;
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [3:0]       LockCnt = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {StIdle, StSync, StCheck, StLocked} state_e;

    // Channel ch expects a period of 2^(ch+1) cycles.
    function automatic logic [CNT_W-1:0] period_of(input int unsigned ch);
        return CNT_W'(32'd2 << ch);
    endfunction

    function automatic logic [CNT_W-1:0] stall_of(input int unsigned ch);
        return CNT_W'(32'd4 << ch);
    endfunction

    logic [NumCh-1:0] din;
    logic [NumCh-1:0] rise;
    logic [NumCh-1:0] fall;
    logic [NumCh-1:0] duty_bad;
    logic [NumCh-1:0] prev_q, prev_d;
    state_e           state_q [NumCh];
    state_e           state_d [NumCh];
    logic [CNT_W-1:0] cnt_q   [NumCh];
    logic [CNT_W-1:0] cnt_d   [NumCh];
    logic [3:0]       good_q  [NumCh];
    logic [3:0]       good_d  [NumCh];
    logic [NumCh-1:0] locked_q, locked_d;
    logic [NumCh-1:0] fault_q, fault_d;
    logic             all_locked_q, all_locked_d;

    assign din  = {clk_div8, clk_div4, clk_div2};
    assign rise = din & ~prev_q;
    assign fall = ~din & prev_q;

`ifdef DUTY_CHECK_EN
    logic [CNT_W-1:0] high_q [NumCh];
    logic [CNT_W-1:0] high_d [NumCh];

    // High time is complete on the falling edge of the registered input.
    always_comb begin
        duty_bad = '0;
        for (int unsigned i = 0; i < NumCh; i++) begin
            high_d[i] = high_q[i];
            if (rise[i]) begin
                high_d[i] = CNT_W'(1);
            end else if (din[i] && (high_q[i] != CntMax)) begin
                high_d[i] = high_q[i] + 1'b1;
            end
            duty_bad[i] = fall[i] && (high_q[i] != (period_of(i) >> 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NumCh; i++) begin
                high_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumCh; i++) begin
                high_q[i] <= high_d[i];
            end
        end
    end
`else
    assign duty_bad = '0;
`endif

    always_comb begin
        prev_d       = din;
        fault_d      = fault_q & ~{NumCh{clr_fault}};
        locked_d     = '0;
        all_locked_d = &locked_q;
        for (int unsigned i = 0; i < NumCh; i++) begin
            state_d[i] = state_q[i];
            good_d[i]  = good_q[i];
            if (rise[i]) begin
                cnt_d[i] = CNT_W'(1);
            end else if (cnt_q[i] == CntMax) begin
                cnt_d[i] = cnt_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end

            if (!en) begin
                state_d[i] = StIdle;
                good_d[i]  = '0;
            end else begin
                unique case (state_q[i])
                    StIdle: begin
                        state_d[i] = StSync;
                    end
                    StSync: begin
                        if (rise[i]) begin
                            good_d[i]  = '0;
                            state_d[i] = StCheck;
                        end
                    end
                    StCheck: begin
                        if (rise[i] && (cnt_q[i] == period_of(i))) begin
                            good_d[i] = good_q[i] + 4'd1;
                            if ((good_q[i] + 4'd1) == LockCnt) begin
                                state_d[i] = StLocked;
                            end
                        end else if (rise[i] || duty_bad[i]) begin
                            good_d[i] = '0;
                        end
                    end
                    StLocked: begin
                        // Set is applied after the clear so a coincident fault wins.
                        if ((rise[i] && (cnt_q[i] != period_of(i))) ||
                            (!rise[i] && (cnt_q[i] == stall_of(i))) || duty_bad[i]) begin
                            fault_d[i] = 1'b1;
                            state_d[i] = StSync;
                        end
                    end
                    default: begin
                        state_d[i] = StIdle;
                    end
                endcase
            end
            locked_d[i] = (state_d[i] == StLocked);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q       <= '0;
            locked_q     <= '0;
            fault_q      <= '0;
            all_locked_q <= 1'b0;
            for (int unsigned i = 0; i < NumCh; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
                good_q[i]  <= '0;
            end
        end else begin
            prev_q       <= prev_d;
            locked_q     <= locked_d;
            fault_q      <= fault_d;
            all_locked_q <= all_locked_d;
            for (int unsigned i = 0; i < NumCh; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                good_q[i]  <= good_d[i];
            end
        end
    end

    assign locked     = locked_q;
    assign fault      = fault_q;
    assign all_locked = all_locked_q;

endmodule

// File: tb/tb_div_ratio_checker.sv
// Randomised and directed bench for div_ratio_checker against a timestamp-based model.
// Honours DUTY_CHECK_EN the same way the design does.
module tb_div_ratio_checker;

    localparam int LOCK = 4;
    localparam int CW   = 5;
    localparam int SAT  = (1 << CW) - 1;
    localparam int MIdle = 0, MSync = 1, MCheck = 2, MLocked = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clr_fault = 1'b0;
    logic [2:0] din = 3'b000;
    logic [2:0] locked;
    logic [2:0] fault;
    logic       all_locked;

    always #5 clk = ~clk;

    div_ratio_checker #(
        .LOCK_COUNT(LOCK),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr_fault (clr_fault),
        .clk_div2  (din[0]),
        .clk_div4  (din[1]),
        .clk_div8  (din[2]),
        .locked    (locked),
        .fault     (fault),
        .all_locked(all_locked)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [2:0] ph = 3'd0;
    logic [2:0] frc_m = 3'b000;
    logic [2:0] frc_v = 3'b000;

    // Model: time of last rising edge / rise-of-high-phase per channel, plus lock bookkeeping.
    int   m_mode [3];
    int   m_good [3];
    int   m_last [3];
    int   m_hrise[3];
    logic [2:0] m_prev = 3'b000;
    logic [2:0] m_locked = 3'b000;
    logic [2:0] m_fault = 3'b000;
    logic       m_all = 1'b0;

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic model_step();
        cyc++;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_mode[i]  = MIdle;
                m_good[i]  = 0;
                m_last[i]  = cyc + 1;
                m_hrise[i] = cyc + 1;
            end
            m_prev   = 3'b000;
            m_locked = 3'b000;
            m_fault  = 3'b000;
            m_all    = 1'b0;
        end else begin
            m_all = &m_locked;
            for (int i = 0; i < 3; i++) begin
                int p;
                int cnt;
                bit r, pbad, stall, dbad;
                p     = 2 << i;
                r     = din[i] && !m_prev[i];
                cnt   = sat(cyc - m_last[i]);
                pbad  = r && (cnt != p);
                stall = !r && (cnt == 2 * p);
                dbad  = 1'b0;
`ifdef DUTY_CHECK_EN
                dbad = !din[i] && m_prev[i] && (sat(cyc - m_hrise[i]) != p / 2);
`endif
                if (clr_fault) m_fault[i] = 1'b0;
                if (!en) begin
                    m_mode[i] = MIdle;
                    m_good[i] = 0;
                end else begin
                    case (m_mode[i])
                        MIdle: m_mode[i] = MSync;
                        MSync: if (r) begin
                            m_good[i] = 0;
                            m_mode[i] = MCheck;
                        end
                        MCheck: begin
                            if (r && !pbad) begin
                                m_good[i]++;
                                if (m_good[i] == LOCK) m_mode[i] = MLocked;
                            end else if (r || dbad) begin
                                m_good[i] = 0;
                            end
                        end
                        default: if (pbad || stall || dbad) begin
                            m_fault[i] = 1'b1;
                            m_mode[i]  = MSync;
                        end
                    endcase
                end
                if (r) begin
                    m_last[i]  = cyc;
                    m_hrise[i] = cyc;
                end
                m_prev[i]   = din[i];
                m_locked[i] = (m_mode[i] == MLocked);
            end
        end
    endtask

    task automatic drive_div();
        ph  = ph + 3'd1;
        din = (ph & ~frc_m) | (frc_v & frc_m);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din = 3'($urandom);
            tick();
        end
        total++;
        if (locked !== 3'b000) begin
            bad++;
            $display("FAIL reset_locked: got %b want 000", locked);
        end
        total++;
        if (fault !== 3'b000) begin
            bad++;
            $display("FAIL reset_fault: got %b want 000", fault);
        end
        total++;
        if (all_locked !== 1'b0) begin
            bad++;
            $display("FAIL reset_all_locked: got %b want 0", all_locked);
        end
    endtask

    task automatic test_lock_from_reset();
        int nlock[3];
        logic [2:0] exp_l;
        // First edge pulse of channel i lands on cycle 2^i+1 after release, then LOCK periods.
        for (int i = 0; i < 3; i++) nlock[i] = (1 << i) + 1 + LOCK * (2 << i);
        rst = 1'b1;
        ph  = 3'd7;
        for (int n = 1; n <= nlock[2] + 3; n++) begin
            drive_div();
            tick();
            for (int i = 0; i < 3; i++) exp_l[i] = (n >= nlock[i]);
            total++;
            if ({locked, all_locked, fault} !== {exp_l, 1'(n >= nlock[2] + 1), 3'b000}) begin
                bad++;
                $display("FAIL lock_timing n=%0d: got l=%b a=%b f=%b want l=%b a=%b f=000",
                         n, locked, all_locked, fault, exp_l, n >= nlock[2] + 1);
            end
            total++;
            if ({locked, fault, all_locked} !== {m_locked, m_fault, m_all}) begin
                bad++;
                $display("FAIL lock_model: got %b want %b", {locked, fault, all_locked},
                         {m_locked, m_fault, m_all});
            end
        end
    endtask

    task automatic test_stall_div4();
        int exp_cyc;
        int seen_cyc;
        exp_cyc  = m_last[1] + 8;
        seen_cyc = -1;
        frc_m    = 3'b010;
        frc_v    = 3'b000;
        for (int k = 0; k < 12; k++) begin
            drive_div();
            tick();
            if (fault[1] === 1'b1 && seen_cyc < 0) seen_cyc = cyc;
            total++;
            if ({locked, fault, all_locked} !== {m_locked, m_fault, m_all}) begin
                bad++;
                $display("FAIL stall_model: got %b want %b", {locked, fault, all_locked},
                         {m_locked, m_fault, m_all});
            end
        end
        total++;
        if (seen_cyc != exp_cyc) begin
            bad++;
            $display("FAIL stall_latency: got cycle %0d want %0d", seen_cyc, exp_cyc);
        end
        total++;
        if ({locked, fault, all_locked} !== {3'b101, 3'b010, 1'b0}) begin
            bad++;
            $display("FAIL stall_state: got l=%b f=%b a=%b want l=101 f=010 a=0",
                     locked, fault, all_locked);
        end
        frc_m = 3'b000;
        for (int k = 0; k < 40; k++) begin
            drive_div();
            tick();
            total++;
            if ({locked, fault, all_locked} !== {m_locked, m_fault, m_all}) begin
                bad++;
                $display("FAIL stall_relock_model: got %b want %b",
                         {locked, fault, all_locked}, {m_locked, m_fault, m_all});
            end
        end
        total++;
        if ({locked, fault, all_locked} !== {3'b111, 3'b010, 1'b1}) begin
            bad++;
            $display("FAIL stall_relock: got l=%b f=%b a=%b want l=111 f=010 a=1",
                     locked, fault, all_locked);
        end
    endtask

    task automatic test_ratio_div8();
        for (int k = 0; k < 8 && ph != 3'd1; k++) begin
            drive_div();
            tick();
            total++;
            if ({locked, fault, all_locked} !== {m_locked, m_fault, m_all}) begin
                bad++;
                $display("FAIL ratio_pre_model: got %b want %b", {locked, fault, all_locked},
                         {m_locked, m_fault, m_all});
            end
        end
        total++;
        if (fault[2] !== 1'b0) begin
            bad++;
            $display("FAIL ratio_before_edge: got fault[2]=%b want 0", fault[2]);
        end
        // Raise div8 two cycles early: a 6-cycle period.
        frc_m = 3'b100;
        frc_v = 3'b100;
        drive_div();
        tick();
        total++;
        if ({locked, fault} !== {3'b011, 3'b110}) begin
            bad++;
            $display("FAIL ratio_fault: got l=%b f=%b want l=011 f=110", locked, fault);
        end
        drive_div();
        tick();
        frc_m = 3'b000;
        for (int k = 0; k < 70; k++) begin
            drive_div();
            tick();
            total++;
            if ({locked, fault, all_locked} !== {m_locked, m_fault, m_all}) begin
                bad++;
                $display("FAIL ratio_model: got %b want %b", {locked, fault, all_locked},
                         {m_locked, m_fault, m_all});
            end
        end
        total++;
        if ({locked, fault} !== {3'b111, 3'b110}) begin
            bad++;
            $display("FAIL ratio_relock: got l=%b f=%b want l=111 f=110", locked, fault);
        end
    endtask

    task automatic test_enable_drop();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_div();
            tick();
            total++;
            if ({locked, fault} !== {3'b000, 3'b110}) begin
                bad++;
                $display("FAIL en_drop: got l=%b f=%b want l=000 f=110", locked, fault);
            end
        end
        en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            drive_div();
            tick();
            total++;
            if (locked !== 3'b000) begin
                bad++;
                $display("FAIL en_early_lock: got %b want 000 at step %0d", locked, k);
            end
        end
        for (int k = 0; k < 50; k++) begin
            drive_div();
            tick();
            total++;
            if ({locked, fault, all_locked} !== {m_locked, m_fault, m_all}) begin
                bad++;
                $display("FAIL en_model: got %b want %b", {locked, fault, all_locked},
                         {m_locked, m_fault, m_all});
            end
        end
        total++;
        if ({locked, all_locked} !== 4'b1111) begin
            bad++;
            $display("FAIL en_relock: got l=%b a=%b want l=111 a=1", locked, all_locked);
        end
    endtask

    task automatic test_reset_mid();
        en = 1'b0;
        drive_div();
        tick();
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_div();
            tick();
        end
        rst = 1'b0;
        drive_div();
        tick();
        rst = 1'b1;
        total++;
        if ({locked, fault, all_locked} !== 7'b0) begin
            bad++;
            $display("FAIL reset_mid: got l=%b f=%b a=%b want all 0", locked, fault, all_locked);
        end
        for (int k = 0; k < 60; k++) begin
            drive_div();
            tick();
            total++;
            if ({locked, fault, all_locked} !== {m_locked, m_fault, m_all}) begin
                bad++;
                $display("FAIL reset_mid_model: got %b want %b", {locked, fault, all_locked},
                         {m_locked, m_fault, m_all});
            end
        end
        total++;
        if ({locked, fault} !== {3'b111, 3'b000}) begin
            bad++;
            $display("FAIL reset_mid_relock: got l=%b f=%b want l=111 f=000", locked, fault);
        end
    endtask

    task automatic test_clr_collision();
        for (int rep = 0; rep < 2; rep++) begin
            frc_m = 3'b001;
            frc_v = 3'b000;
            for (int k = 0; k < 8; k++) begin
                // Second pass: pulse clear on the cycle the div2 stall is flagged.
                clr_fault = (rep == 1) && ((cyc + 1 - m_last[0]) == 4);
                drive_div();
                tick();
                clr_fault = 1'b0;
                total++;
                if ({locked, fault, all_locked} !== {m_locked, m_fault, m_all}) begin
                    bad++;
                    $display("FAIL clr_model: got %b want %b", {locked, fault, all_locked},
                             {m_locked, m_fault, m_all});
                end
            end
            total++;
            if (fault[0] !== 1'b1) begin
                bad++;
                $display("FAIL clr_set_wins pass %0d: got fault[0]=%b want 1", rep, fault[0]);
            end
            frc_m = 3'b000;
            for (int k = 0; k < 30; k++) begin
                drive_div();
                tick();
            end
            total++;
            if (locked[0] !== 1'b1) begin
                bad++;
                $display("FAIL clr_relock pass %0d: got locked[0]=%b want 1", rep, locked[0]);
            end
        end
        clr_fault = 1'b1;
        drive_div();
        tick();
        clr_fault = 1'b0;
        total++;
        if (fault !== 3'b000) begin
            bad++;
            $display("FAIL clr_quiet: got %b want 000", fault);
        end
    endtask

    task automatic test_duty();
        logic seen;
        seen = 1'b0;
        rst  = 1'b0;
        drive_div();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 60; k++) begin
            drive_div();
            din[1] = (ph[1:0] == 2'd2);
            tick();
            if (locked[1] === 1'b1) seen = 1'b1;
            total++;
            if ({locked, fault, all_locked} !== {m_locked, m_fault, m_all}) begin
                bad++;
                $display("FAIL duty_model: got %b want %b", {locked, fault, all_locked},
                         {m_locked, m_fault, m_all});
            end
        end
`ifdef DUTY_CHECK_EN
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL duty_no_lock: got seen_lock=%b want 0", seen);
        end
`else
        total++;
        if (locked[1] !== 1'b1) begin
            bad++;
            $display("FAIL duty_locks: got locked[1]=%b want 1", locked[1]);
        end
`endif
        total++;
        if (fault !== 3'b000) begin
            bad++;
            $display("FAIL duty_fault: got %b want 000", fault);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 999) != 0);
            en        = ($urandom_range(0, 99) != 0);
            clr_fault = ($urandom_range(0, 49) == 0);
            drive_div();
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 99) == 0) din[i] = ~din[i];
            end
            tick();
            total++;
            if ({locked, fault, all_locked} !== {m_locked, m_fault, m_all}) begin
                bad++;
                $display("FAIL random_model cyc=%0d: got %b want %b", cyc,
                         {locked, fault, all_locked}, {m_locked, m_fault, m_all});
            end
        end
        rst       = 1'b1;
        en        = 1'b1;
        clr_fault = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_from_reset();
        test_stall_div4();
        test_ratio_div8();
        test_enable_drop();
        test_reset_mid();
        test_clr_collision();
        test_duty();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
